// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and first-exception-wins merge. A bubble is always an all-zero entry.
module pipe_stage_reg #(
  parameter int PAYLOAD_W = 165,
  parameter int EXC_W     = 5,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic                 in_bd,
  input  logic [EXC_W-1:0]     local_exc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [EXC_W-1:0]     out_exc,
  output logic                 out_bd,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [EXC_W-1:0]     exc;
    logic                 bd;
  } entry_t;

  localparam int ENTRY_W = PAYLOAD_W + EXC_W + 1;
  localparam logic [ENTRY_W-1:0] ZERO_BITS = {ENTRY_W{1'b0}};

  // An exception raised earlier in the pipe always outranks the one found by this stage.
  function automatic logic [EXC_W-1:0] merge_exc(input logic [EXC_W-1:0] up_exc,
                                                 input logic [EXC_W-1:0] here_exc);
    return (up_exc != {EXC_W{1'b0}}) ? up_exc : here_exc;
  endfunction

  state_t state_r, state_s;
  entry_t head_r, head_s, skid_r, skid_s, new_entry_s;
  logic   accept_s, retire_s;

  // State register and entry storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
      head_r  <= entry_t'(ZERO_BITS);
      skid_r  <= entry_t'(ZERO_BITS);
    end else begin
      state_r <= state_s;
      head_r  <= head_s;
      skid_r  <= skid_s;
    end
  end

  // Next-state and next-entry logic; flush overrides every transfer in the same edge.
  always_comb begin
    accept_s            = in_valid & in_ready;
    retire_s            = out_valid & out_ready;
    new_entry_s.payload = in_payload;
    new_entry_s.exc     = merge_exc(in_exc, local_exc);
    new_entry_s.bd      = in_bd;
    state_s             = state_r;
    head_s              = head_r;
    skid_s              = skid_r;
    if (flush) begin
      state_s = ST_EMPTY;
      head_s  = entry_t'(ZERO_BITS);
      skid_s  = entry_t'(ZERO_BITS);
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s = ST_ONE;
            head_s  = new_entry_s;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && retire_s) begin
            head_s = new_entry_s;
          end else if (accept_s && SKID_EN) begin
            state_s = ST_TWO;
            skid_s  = new_entry_s;
          end else if (retire_s) begin
            state_s = ST_EMPTY;
            head_s  = entry_t'(ZERO_BITS);
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (retire_s) begin
            state_s = ST_ONE;
            head_s  = skid_r;
            skid_s  = entry_t'(ZERO_BITS);
          end else begin
            state_s = ST_TWO;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          head_s  = entry_t'(ZERO_BITS);
          skid_s  = entry_t'(ZERO_BITS);
        end
      endcase
    end
  end

  // Output decode; with the skid enabled in_ready depends on flops only.
  always_comb begin
    out_payload = head_r.payload;
    out_exc     = head_r.exc;
    out_bd      = head_r.bd;
    out_valid   = 1'b0;
    occupancy   = 2'd0;
    in_ready    = 1'b1;
    case (state_r)
      ST_EMPTY: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        in_ready  = 1'b1;
      end
      ST_ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
        if (SKID_EN) begin
          in_ready = 1'b1;
        end else begin
          in_ready = out_ready;
        end
      end
      ST_TWO: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
        in_ready  = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
        occupancy = 2'd0;
        in_ready  = 1'b0;
      end
    endcase
  end

endmodule
